tl_ul_sram_responder: RTL and testbench



---
 rtl/tl_ul_sram_responder.sv | 153 +++++++++++++++
 tb/tb_tl_ul_sram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_sram_responder.sv
// tl_ul_sram_responder
//   TileLink-UL responder endpoint that terminates the A channel and returns
//   D-channel responses. The backing store is a word-addressed register array
//   of DEPTH 32-bit words with byte-lane writes. The design accepts one
//   request per cycle and holds each response in a single output register.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   a_valid/a_ready       A-channel handshake (a_ready is combinational)
//   a_opcode..a_corrupt   A-channel request fields (a_param is ignored)
//   d_valid/d_ready       D-channel handshake
//   d_opcode..d_corrupt   registered D-channel response fields
module tl_ul_sram_responder #(
  parameter int DEPTH    = 64,
  parameter int SOURCE_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [11:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITHMETIC  = 3'd2;
  localparam logic [2:0] OP_LOGICAL     = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  logic [31:0]      mem [DEPTH];
  logic             a_fire;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             err;
  logic             do_write;
  logic [2:0]       rsp_opcode;
  logic             rsp_denied;
  logic             rsp_corrupt;
  logic [31:0]      rsp_data;
  logic             unused_param;

  assign unused_param = ^a_param;

  // The response register can take a new entry whenever it is empty or is
  // being drained this very cycle.
  assign a_ready = !d_valid || d_ready;
  assign a_fire  = a_valid && a_ready;
  assign idx     = a_address[2 +: IDX_W];

  always_comb begin
    misaligned = 1'b0;
    case (a_size)
      2'd1:    misaligned = a_address[0];
      2'd2:    misaligned = |a_address[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Comparing the whole word address against DEPTH covers both an index
  // past the array and any set address bits above the index field.
  assign err = (32'(a_address[11:2]) >= DEPTH) || (a_size > 2'd2) || misaligned;

  always_comb begin
    do_write    = 1'b0;
    rsp_opcode  = D_HINT_ACK;
    rsp_denied  = 1'b0;
    rsp_corrupt = 1'b0;
    rsp_data    = '0;
    case (a_opcode)
      OP_PUT_FULL, OP_PUT_PARTIAL: begin
        rsp_opcode = D_ACCESS_ACK;
        if (err || a_corrupt) rsp_denied = 1'b1;
        else                  do_write   = 1'b1;
      end
      OP_ARITHMETIC, OP_LOGICAL: begin
        rsp_opcode  = D_ACCESS_ACK_DATA;
        rsp_denied  = 1'b1;
        rsp_corrupt = 1'b1;
      end
      OP_GET: begin
        rsp_opcode = D_ACCESS_ACK_DATA;
        if (err) begin
          rsp_denied  = 1'b1;
          rsp_corrupt = 1'b1;
        end else begin
          rsp_data = mem[idx];
        end
      end
      default: rsp_opcode = D_HINT_ACK;  // Intent and reserved opcodes
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (a_fire && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // A simultaneous drain and accept simply overwrites the register, so
  // d_valid stays high through back-to-back traffic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else if (a_fire) begin
      d_valid   <= 1'b1;
      d_opcode  <= rsp_opcode;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= rsp_denied;
      d_data    <= rsp_data;
      d_corrupt <= rsp_corrupt;
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end

  assign d_param = 2'd0;
  assign d_sink  = 1'b0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
module tb_tl_ul_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [2:0]  a_source;
  logic [11:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [2:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  tl_ul_sram_responder #(.DEPTH(64), .SOURCE_W(3)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [2:0]  src;
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] op, logic [1:0] size, logic [2:0] src,
                              logic [11:0] addr, logic [3:0] mask, logic [31:0] data,
                              logic corrupt, logic [2:0] e_op, logic e_den,
                              logic e_cor, logic [31:0] e_data);
    vec_t v;
    v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask;
    v.data = data; v.corrupt = corrupt; v.e_op = e_op; v.e_den = e_den;
    v.e_cor = e_cor; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] size, input logic [2:0] src,
                       input logic [11:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic corrupt);
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0; a_source = 3'd0;
    a_address = 12'd0; a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [2:0] op, input logic den,
                           input logic cor, input logic [31:0] data,
                           input logic [1:0] size, input logic [2:0] src);
    check({tag, " d_valid"},   32'(d_valid),   32'd1);
    check({tag, " d_opcode"},  32'(d_opcode),  32'(op));
    check({tag, " d_denied"},  32'(d_denied),  32'(den));
    check({tag, " d_corrupt"}, 32'(d_corrupt), 32'(cor));
    check({tag, " d_data"},    d_data,         data);
    check({tag, " d_size"},    32'(d_size),    32'(size));
    check({tag, " d_source"},  32'(d_source),  32'(src));
  endtask

  // Single isolated request with d_ready high; checks the response one edge later.
  task automatic single(input string tag, input logic [2:0] op, input logic [1:0] size,
                        input logic [2:0] src, input logic [11:0] addr,
                        input logic [31:0] e_data);
    @(negedge clock);
    drive(op, size, src, addr, 4'hF, 32'd0, 1'b0);
    d_ready = 1'b1;
    @(posedge clock); #1;
    check_rsp(tag, 3'd1, 1'b0, 1'b0, e_data, size, src);
    idle();
  endtask

  vec_t b2b[3];
  logic [31:0] held_data;

  initial begin
    idle();
    d_ready = 1'b1;
    reset   = 1'b1;
    #12;
    check("reset d_valid",  32'(d_valid),  32'd0);
    check("reset a_ready",  32'(a_ready),  32'd1);
    check("reset d_opcode", 32'(d_opcode), 32'd0);
    check("reset d_data",   d_data,        32'd0);
    check("reset d_denied", 32'(d_denied), 32'd0);
    check("reset d_param",  32'(d_param),  32'd0);
    check("reset d_sink",   32'(d_sink),   32'd0);
    @(negedge clock);
    reset = 1'b0;

    //                 op    sz  src addr    mask  data          cor  eop den cor e_data
    vecs.push_back(mk(3'd4, 2, 3'd5, 12'h010, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'h00000000));
    vecs.push_back(mk(3'd0, 2, 3'd1, 12'h040, 4'hF, 32'hDEADBEEF, 0, 3'd0, 0, 0, 32'h0));
    vecs.push_back(mk(3'd1, 2, 3'd2, 12'h040, 4'h2, 32'h00001200, 0, 3'd0, 0, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd3, 12'h040, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd4, 2, 3'd4, 12'h100, 4'hF, 32'h0,        0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(3'd0, 2, 3'd6, 12'h042, 4'hF, 32'h11111111, 0, 3'd0, 1, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd7, 12'h040, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd0, 2, 3'd0, 12'h040, 4'hF, 32'h22222222, 1, 3'd0, 1, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd1, 12'h040, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd2, 2, 3'd2, 12'h040, 4'hF, 32'h33333333, 0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(3'd3, 2, 3'd3, 12'h040, 4'hF, 32'h44444444, 0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(3'd5, 2, 3'd4, 12'h040, 4'hF, 32'h0,        0, 3'd2, 0, 0, 32'h0));
    vecs.push_back(mk(3'd7, 2, 3'd5, 12'h040, 4'hF, 32'h0,        0, 3'd2, 0, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd6, 12'h040, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd4, 3, 3'd7, 12'h040, 4'hF, 32'h0,        0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(3'd4, 1, 3'd0, 12'h042, 4'hC, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd4, 0, 3'd1, 12'h043, 4'h8, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd1, 1, 3'd2, 12'h041, 4'h3, 32'h0000FFFF, 0, 3'd0, 1, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd3, 12'h040, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF));
    vecs.push_back(mk(3'd0, 2, 3'd4, 12'h0FC, 4'hF, 32'hA5A5A5A5, 0, 3'd0, 0, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd5, 12'h0FC, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hA5A5A5A5));
    vecs.push_back(mk(3'd4, 2, 3'd6, 12'h800, 4'hF, 32'h0,        0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(3'd0, 2, 3'd7, 12'h800, 4'hF, 32'h55555555, 0, 3'd0, 1, 0, 32'h0));
    vecs.push_back(mk(3'd4, 2, 3'd0, 12'h000, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask,
            vecs[i].data, vecs[i].corrupt);
      d_ready = 1'b1;
      check($sformatf("v%0d a_ready", i), 32'(a_ready), 32'd1);
      @(posedge clock); #1;
      check_rsp($sformatf("v%0d", i), vecs[i].e_op, vecs[i].e_den, vecs[i].e_cor,
                vecs[i].e_data, vecs[i].size, vecs[i].src);
      idle();
    end

    // Back-to-back Put/PutPartial/Get on a fresh word with d_ready held high.
    b2b[0] = mk(3'd0, 2, 3'd1, 12'h080, 4'hF, 32'hDEADBEEF, 0, 3'd0, 0, 0, 32'h0);
    b2b[1] = mk(3'd1, 2, 3'd2, 12'h080, 4'h2, 32'h00001200, 0, 3'd0, 0, 0, 32'h0);
    b2b[2] = mk(3'd4, 2, 3'd3, 12'h080, 4'hF, 32'h0,        0, 3'd1, 0, 0, 32'hDEAD12EF);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      drive(b2b[k].op, b2b[k].size, b2b[k].src, b2b[k].addr, b2b[k].mask, b2b[k].data, 1'b0);
      @(posedge clock); #1;
      check_rsp($sformatf("b2b%0d", k), b2b[k].e_op, b2b[k].e_den, b2b[k].e_cor,
                b2b[k].e_data, b2b[k].size, b2b[k].src);
      check($sformatf("b2b%0d a_ready", k), 32'(a_ready), 32'd1);
      @(negedge clock);
    end
    idle();
    @(posedge clock); #1;
    check("b2b drain d_valid", 32'(d_valid), 32'd0);

    // Backpressure: first response must hold while d_ready is low.
    @(negedge clock);
    d_ready = 1'b0;
    drive(3'd4, 2, 3'd3, 12'h080, 4'hF, 32'h0, 1'b0);
    @(posedge clock); #1;
    check_rsp("bp first", 3'd1, 1'b0, 1'b0, 32'hDEAD12EF, 2'd2, 3'd3);
    drive(3'd4, 2, 3'd6, 12'h0FC, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check($sformatf("bp%0d a_ready", k), 32'(a_ready), 32'd0);
      check_rsp($sformatf("bp%0d hold", k), 3'd1, 1'b0, 1'b0, 32'hDEAD12EF, 2'd2, 3'd3);
    end
    @(negedge clock);
    d_ready = 1'b1;
    #1;
    check("bp release a_ready", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    check_rsp("bp second", 3'd1, 1'b0, 1'b0, 32'hA5A5A5A5, 2'd2, 3'd6);
    idle();
    @(posedge clock); #1;
    check("bp drain d_valid", 32'(d_valid), 32'd0);

    // Reset while a response is stalled.
    @(negedge clock);
    d_ready = 1'b0;
    drive(3'd4, 2, 3'd2, 12'h040, 4'hF, 32'h0, 1'b0);
    @(posedge clock); #1;
    idle();
    held_data = d_data;
    check("pre-reset d_valid", 32'(d_valid), 32'd1);
    check("pre-reset d_data", held_data, 32'hDEAD12EF);
    #2;
    reset = 1'b1;
    #1;
    check("async reset d_valid", 32'(d_valid), 32'd0);
    check("async reset d_data",  d_data,       32'd0);
    check("async reset a_ready", 32'(a_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    single("post-reset 0x040", 3'd4, 2'd2, 3'd1, 12'h040, 32'h0);
    single("post-reset 0x080", 3'd4, 2'd2, 3'd2, 12'h080, 32'h0);
    single("post-reset 0x0FC", 3'd4, 2'd2, 3'd3, 12'h0FC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
